// File: rtl/z80_int_ctrl.sv
// z80_int_ctrl: device end of the Z80 IM2 maskable-interrupt handshake for tv80s.
// Latches rising edges of four external sources and a periodic timer into PEND,
// drives int_n_o, answers INTACK with a vector byte and holds off until EOI.
//
// Ports:
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   m1_n       CPU M1 (active low)
//   iorq_n     CPU IORQ (active low)
//   rd_n       CPU RD (active low)
//   wr_n       CPU WR (active low)
//   addr_i     CPU address [7:0]
//   data_i     CPU write data
//   irq_src_i  peripheral request levels, synchronous to clk_i
//   data_o     register read data or interrupt vector
//   cs_o       block drives data_o this cycle
//   int_n_o    interrupt request to CPU, active low
module z80_int_ctrl #(
  parameter logic [7:0]  IO_BASE  = 8'h18,
  parameter int unsigned PRESCALE = 27
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       m1_n,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] addr_i,
  input  logic [7:0] data_i,
  input  logic [3:0] irq_src_i,
  output logic [7:0] data_o,
  output logic       cs_o,
  output logic       int_n_o
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PreMax = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {StIdle, StAck, StService} state_e;

  state_e      state_q, state_d;
  logic [3:0]  vec_q;
  logic [4:0]  en_q;
  logic [4:0]  pend_q, pend_d;
  logic [7:0]  tlo_q, thi_q;
  logic        run_q;
  logic [15:0] cnt_q, cnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]  src_q;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  svc_q, svc_d;
  logic        wr_act_q, intack_q;

  logic        sel, intack, wr_act, wr_stb;
  logic [2:0]  reg_sel;
  logic        tick, timer_set;
  logic [4:0]  active, set_v, clr_v, ack_clr, w1c;
  logic [2:0]  first_idx;
  logic [7:0]  rd_data;

  assign sel     = !iorq_n && m1_n && (addr_i[7:3] == IO_BASE[7:3]);
  assign reg_sel = addr_i[2:0];
  assign intack  = !m1_n && !iorq_n;
  assign wr_act  = sel && !wr_n;
  // One strobe per bus write, however many cycles WR stays low.
  assign wr_stb  = wr_act && !wr_act_q;
  assign active  = pend_q & en_q;

  // Prescaler and reload counter.
  always_comb begin
    pre_d     = pre_q;
    tick      = 1'b0;
    cnt_d     = cnt_q;
    timer_set = 1'b0;
    if (run_q) begin
      if (pre_q == PreMax) begin
        pre_d = '0;
        tick  = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
    if (tick) begin
      if (cnt_q == 16'd0) begin
        timer_set = 1'b1;
        cnt_d     = {thi_q, tlo_q};
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
    end
    if (wr_stb && reg_sel == 3'd5) cnt_d = {data_i, tlo_q};
  end

  // Fixed priority: lowest index wins.
  always_comb begin
    first_idx = 3'd7;
    for (int i = 4; i >= 0; i--) begin
      if (active[i]) first_idx = 3'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    svc_d   = svc_q;
    ack_clr = '0;
    case (state_q)
      StIdle: begin
        // Only the start of INTACK is answered, so a reset mid-cycle does not re-ack.
        if (intack && !intack_q) begin
          idx_d   = first_idx;
          state_d = StAck;
        end
      end
      StAck: begin
        if (iorq_n) begin
          if (idx_q != 3'd7) begin
            ack_clr = 5'b1 << idx_q;
            svc_d   = idx_q;
            state_d = StService;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StService: begin
        if (wr_stb && reg_sel == 3'd3) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Set beats clear for edges and the timer.
  always_comb begin
    w1c    = (wr_stb && reg_sel == 3'd2) ? data_i[4:0] : 5'd0;
    set_v  = {timer_set, irq_src_i & ~src_q};
    clr_v  = w1c | ack_clr;
    pend_d = (pend_q & ~clr_v) | set_v;
  end

  always_comb begin
    case (reg_sel)
      3'd0:    rd_data = {vec_q, 4'b0};
      3'd1:    rd_data = {3'b0, en_q};
      3'd2:    rd_data = {3'b0, pend_q};
      3'd3:    rd_data = {state_q == StService, 4'b0, svc_q};
      3'd4:    rd_data = tlo_q;
      3'd5:    rd_data = thi_q;
      3'd6:    rd_data = {7'b0, run_q};
      default: rd_data = 8'h00;
    endcase
  end

  always_comb begin
    int_n_o = 1'b1;
    cs_o    = 1'b0;
    data_o  = 8'h00;
    if (state_q == StIdle) int_n_o = ~|active;
    if (state_q == StAck) begin
      cs_o   = 1'b1;
      data_o = {vec_q, idx_q, 1'b0};
    end else if (sel && !rd_n) begin
      cs_o   = 1'b1;
      data_o = rd_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      vec_q    <= '0;
      en_q     <= '0;
      pend_q   <= '0;
      tlo_q    <= '0;
      thi_q    <= '0;
      run_q    <= 1'b0;
      cnt_q    <= '0;
      pre_q    <= '0;
      idx_q    <= '0;
      svc_q    <= '0;
      // History follows the live inputs so levels held through reset are not edges.
      src_q    <= irq_src_i;
      wr_act_q <= wr_act;
      intack_q <= intack;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      svc_q    <= svc_d;
      src_q    <= irq_src_i;
      wr_act_q <= wr_act;
      intack_q <= intack;
      if (wr_stb) begin
        case (reg_sel)
          3'd0:    vec_q <= data_i[7:4];
          3'd1:    en_q  <= data_i[4:0];
          3'd4:    tlo_q <= data_i;
          3'd5:    thi_q <= data_i;
          3'd6:    run_q <= data_i[0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/z80_int_ctrl.md
Name: z80_int_ctrl

Overview:
- Interrupt requester/responder for the tv80s CPU's maskable interrupt input: the device end of the Z80 IM2 interrupt handshake.
- Collects four external edge sources (UART RX, keyboard, SD, spare) plus an internal periodic timer. Drives int_n, answers the INTACK cycle with a vector byte and holds off further requests until software writes EOI.
- Sits on the CPU I/O bus beside addr_decoder, uart and leds; its data_o enters the CPU data input mux gated by cs_o.

Parameters:
- IO_BASE, 8'h18, I/O base port; block decodes IO_BASE[7:3], 8 registers.
- PRESCALE, 27, clk_i cycles per timer tick (1 us at 27 MHz); must be >= 1.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- m1_n  in  1  CPU M1
- iorq_n  in  1  CPU IORQ
- rd_n  in  1  CPU RD
- wr_n  in  1  CPU WR
- addr_i  in  8  CPU address [7:0]
- data_i  in  8  CPU data out
- irq_src_i  in  4  peripheral request levels, synchronous to clk_i
- data_o  out  8  read data / vector
- cs_o  out  1  block drives data_o this cycle (to CPU data mux)
- int_n_o  out  1  to CPU int_n, active low

Behaviour:
- Reset (rst_i high at a clk_i edge): data_o=0, cs_o=0, int_n_o=1. VEC, EN, PEND, TLO, THI, TCTL, counter and prescaler cleared. State IDLE. Edge-detect history loaded with current irq_src_i, so a high level at reset does not register as an edge. Reset mid-INTACK or mid-service aborts with no pending bit cleared late.
- Select: sel = !iorq_n & m1_n & (addr_i[7:3]==IO_BASE[7:3]). reg = addr_i[2:0].
- Write: one strobe per cycle, on the first clk_i where sel & !wr_n (edge-detected against the previous cycle). Register updates are visible the next cycle.
- Read: combinational. cs_o=1 and data_o=reg value while sel & !rd_n.
- Register map:
  - 0 VEC RW: bits 7:4 only; bits 3:0 read 0.
  - 1 EN RW: bits 4:0.
  - 2 PEND: read bits 4:0; write-1-to-clear.
  - 3 EOI: any write ends service. Read {in_service, 4'b0, svc_idx[2:0]}.
  - 4 TLO RW.
  - 5 THI RW; a write also loads counter with {THI_new, TLO}.
  - 6 TCTL RW bit0 = run.
  - 7 reads 0.
- Sources: PEND[i] (i=0..3) sets on a rising edge of irq_src_i[i]. PEND[4] is the timer.
- Set beats clear: if an edge and a W1C (or an ack clear) hit the same bit in the same cycle, the bit stays 1.
- Timer: when run=1, prescaler counts 0..PRESCALE-1 and emits one tick on wrap.
  - On tick: counter==0 sets PEND[4] and reloads {THI,TLO}; otherwise counter decrements.
  - Period = ({THI,TLO}+1)*PRESCALE cycles.
  - run=0 freezes prescaler and counter.
- FSM:
  - IDLE: int_n_o = !(|(PEND&EN)). On INTACK (!m1_n & !iorq_n), latch idx = lowest set bit of PEND&EN, or 7 if none (spurious), then go to ACK.
  - ACK: int_n_o=1, cs_o=1, data_o={VEC[7:4], idx, 1'b0} for the whole INTACK. On iorq_n returning high, clear PEND[idx] (if idx != 7), set svc_idx=idx, then go to SERVICE; a spurious ack (idx=7) returns to IDLE.
  - SERVICE: int_n_o=1. An EOI write returns to IDLE, and int_n_o may reassert on the next cycle. Sources keep latching while in service.
- Priority: fixed, index 0 highest. The vector is latched at INTACK start and does not change if PEND changes during ACK.

Test Plan:
- Reset, then read all regs -> every reg reads 0, int_n_o=1. Hold irq_src_i=4'hF through reset -> PEND stays 0.
- Write VEC=8'hA0, EN=8'h1F. Pulse irq_src_i[2] -> PEND=8'h04, int_n_o=0. Run INTACK -> data_o=8'hA4 with cs_o=1. After iorq_n rises: PEND=0, EOI read=8'h82, int_n_o=1. Write EOI -> int_n_o stays 1.
- Pulse src1 and src3 together with EN=8'h0A -> vector 8'hA2 first. After EOI, int_n_o=0 again and the next INTACK gives vector 8'hA6.
- TLO=2, THI=0, TCTL=1, PRESCALE=4 -> PEND[4] sets every 12 clk_i cycles. Writing TCTL=0 stops it.
- Edge on src0 in the same cycle as a W1C of PEND bit0 -> PEND[0]=1.
- Set int_n_o=0, then clear EN to 0 before INTACK -> vector 8'hAE, FSM returns to IDLE with no SERVICE. Assert rst_i during ACK -> next cycle int_n_o=1, cs_o=0.
